trace_filter_stream: RTL and testbench
======================================

Name: trace_filter_stream

Overview:
Parametrised, pipelined successor to the combinational control-flow trace filter.
- Accepts a valid/ready stream of retired (pc, instr) pairs from the core trace port.
- Classifies each instruction against built-in control-flow classes and NUM_RULES programmable mask/match rules.
- Forwards or silently drops each instruction according to a programmable mode.
- Keeps saturating pass/drop counters.
- Sits between the core trace tap and the trace storage FIFO / host interface.

Parameters:
PC_WIDTH, 32, width of pc path (1..32).
NUM_RULES, 4, number of mask/match rule pairs (0..6).
CNT_WIDTH, 32, width of pass/drop counters.
RV32, 1, when 1, C.JAL (quadrant 01, funct3 001) is counted in class C_J.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input entry valid
in_ready  out  1  input entry accepted when in_valid & in_ready
in_pc  in  PC_WIDTH  pc of instruction
in_instr  in  32  instruction word
out_valid  out  1  kept entry available
out_ready  in  1  downstream accepts
out_pc  out  PC_WIDTH  registered pc
out_instr  out  32  registered instruction
out_class  out  7  class bits that hit for this entry
cfg_wr_en  in  1  config write strobe
cfg_addr  in  4  config register index
cfg_wdata  in  32  config write data
pass_count  out  CNT_WIDTH  entries forwarded
drop_count  out  CNT_WIDTH  entries dropped

Behaviour:
Clock and reset:
- One clock, clk. Reset rst is synchronous and active-high.

Classes (combinational on in_instr), bit index: meaning:
- 0 BRANCH: [6:0]=1100011.
- 1 JAL: [6:0]=1101111.
- 2 JALR: [6:0]=1100111.
- 3 C_BRANCH: [1:0]=01, [15:14]=11.
- 4 C_J: [1:0]=01, [15:13]=101, or [15:13]=001 when RV32=1.
- 5 C_JR/C_JALR: [1:0]=10, [15:13]=100, [6:2]=0, [11:7]!=0.
- 6 WFI: instr==32'h10500073.
- Compressed classes require [1:0]!=11.

Match:
- match = |(class & class_en) | rule_hit.
- Rule k hits when mask_k!=0 and (in_instr & mask_k)==match_k.

Mode (cfg reg 0, bits [1:0]); keep is:
- 0 PASS_ALL: 1.
- 1 KEEP_MATCH: match.
- 2 DROP_MATCH: !match.
- 3 DROP_ALL: 0.

Config registers:
- 0: mode.
- 1: class_en [6:0].
- 2+2k: mask_k.
- 3+2k: match_k.
- 15: counter clear (data ignored).
- Writes to unimplemented addresses are ignored.
- A write takes effect for entries accepted from the next cycle onward; an entry accepted in the write cycle uses the old values.

Pipeline (single stage, register s1):
- On accept, s1 captures pc, instr, class, keep; s1_valid<=1.
- out_valid = s1_valid & s1_keep; out_* driven from s1.
- s1 retires when s1_valid & (!s1_keep | out_ready).
- in_ready = !s1_valid | !s1_keep | out_ready (combinational from out_ready). Full throughput of 1 entry/cycle is possible.
- Accept and retire in the same cycle: s1 is overwritten and s1_valid stays 1.
- Latency: accept at cycle N gives out_valid at N+1.
- Held out_valid keeps out_pc/out_instr/out_class stable until accepted.

Counters:
- pass_count increments on retire with keep=1; drop_count increments on retire with keep=0.
- Both saturate at all-ones.
- Clear (reg 15 write) wins over a simultaneous increment.

Reset:
- s1_valid=0, so out_valid=0; out_pc, out_instr, out_class=0; in_ready=1.
- Counters=0, mode=1, class_en=7'h7F, all masks/matches=0.
- Reset mid-transfer discards s1 without counting it.

Optional Feature:
Macro TRACE_FILTER_PC_RANGE_EN.
- Defined: adds cfg reg 12 pc_lo and reg 13 pc_hi (low PC_WIDTH bits of cfg_wdata).
  - Reset values: pc_lo=0, pc_hi=all-ones.
  - Final keep = mode_keep & (pc_lo <= in_pc <= pc_hi), unsigned and inclusive.
  - pc_lo > pc_hi drops everything.
- Undefined: regs 12/13 are absent (writes ignored) and no range qualification is applied.

Test Plan:
- Reset then stream 0x00000063, 0x00000013, 0x10500073 with out_ready=1 -> out gives 0x63 then 0x10500073, each one cycle after accept; pass_count=2, drop_count=1.
- Write mode=0, stream 4 instructions with out_ready=0 -> first entry held stable, in_ready=0, others stalled; release out_ready -> all 4 emitted in order with no duplicates.
- Write mask_0=0x7F, match_0=0x33, class_en=0, mode=1; send 0x00B50533 and 0x0000006F -> only 0x00B50533 passes, out_class=0.
- Mode=2 with default class_en; send 16'h8082 (C.JR ra) and 16'h8002 (rs1=0) -> C.JR dropped, 0x8002 passed.
- Preload drop_count near all-ones with CNT_WIDTH=4; drop 20 entries -> drop_count=4'hF; clear write in the same cycle as a drop -> 0.
- With TRACE_FILTER_PC_RANGE_EN: pc_lo=0x100, pc_hi=0x1FF, mode=0; pcs 0xFF, 0x100, 0x1FF, 0x200 -> only 0x100 and 0x1FF pass.

Source files
------------

// File: rtl/trace_filter_stream.sv
// trace_filter_stream: pipelined control-flow trace filter.
// Classifies retired (pc, instr) pairs against fixed control-flow classes
// and programmable mask/match rules, then forwards or drops each entry
// according to the filter mode. Keeps saturating pass/drop counters.
// Optional feature macro: TRACE_FILTER_PC_RANGE_EN adds an inclusive
// pc_lo/pc_hi window (cfg regs 12/13) that qualifies every keep decision.
module trace_filter_stream #(
  parameter int PC_WIDTH  = 32,
  parameter int NUM_RULES = 4,
  parameter int CNT_WIDTH = 32,
  parameter int RV32      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PC_WIDTH-1:0]  in_pc,
  input  logic [31:0]          in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_WIDTH-1:0]  out_pc,
  output logic [31:0]          out_instr,
  output logic [6:0]           out_class,
  input  logic                 cfg_wr_en,
  input  logic [3:0]           cfg_addr,
  input  logic [31:0]          cfg_wdata,
  output logic [CNT_WIDTH-1:0] pass_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  // Rule storage keeps at least one slot so the arrays stay legal when
  // NUM_RULES is 0; unused slots never hit and are never written.
  localparam int NR = (NUM_RULES > 0) ? NUM_RULES : 1;

  localparam logic [3:0] ADDR_MODE     = 4'd0;
  localparam logic [3:0] ADDR_CLASS_EN = 4'd1;
  localparam logic [3:0] ADDR_CLEAR    = 4'd15;

  localparam logic [1:0] MODE_PASS_ALL   = 2'd0;
  localparam logic [1:0] MODE_KEEP_MATCH = 2'd1;
  localparam logic [1:0] MODE_DROP_MATCH = 2'd2;
  localparam logic [1:0] MODE_DROP_ALL   = 2'd3;

  // Configuration state
  logic [1:0]  mode_reg;
  logic [6:0]  class_en_reg;
  logic [31:0] mask_reg  [NR];
  logic [31:0] match_reg [NR];

  // Pipeline stage s1
  logic                s1_valid_reg;
  logic                s1_keep_reg;
  logic [PC_WIDTH-1:0] s1_pc_reg;
  logic [31:0]         s1_instr_reg;
  logic [6:0]          s1_class_reg;

  // Counters
  logic [CNT_WIDTH-1:0] pass_count_reg;
  logic [CNT_WIDTH-1:0] drop_count_reg;

  // Decode / classification
  logic [6:0]    cls;
  logic          is_compressed;
  logic [NR-1:0] rule_hit;
  logic          match;
  logic          mode_keep;
  logic          in_range;
  logic          keep;
  logic          rule_addr_ok;
  logic          cnt_clear;

  // Handshake
  logic accept;
  logic retire;

  // Built-in control-flow classes, purely from the instruction word
  always_comb begin
    cls           = '0;
    is_compressed = (in_instr[1:0] != 2'b11);
    cls[0] = (in_instr[6:0] == 7'b1100011);
    cls[1] = (in_instr[6:0] == 7'b1101111);
    cls[2] = (in_instr[6:0] == 7'b1100111);
    cls[3] = is_compressed && (in_instr[1:0] == 2'b01) && (in_instr[15:14] == 2'b11);
    cls[4] = is_compressed && (in_instr[1:0] == 2'b01) &&
             ((in_instr[15:13] == 3'b101) ||
              ((RV32 != 0) && (in_instr[15:13] == 3'b001)));
    cls[5] = is_compressed && (in_instr[1:0] == 2'b10) &&
             (in_instr[15:13] == 3'b100) && (in_instr[6:2] == 5'd0) &&
             (in_instr[11:7] != 5'd0);
    cls[6] = (in_instr == 32'h1050_0073);
  end

  // A rule with an all-zero mask is disabled rather than matching everything
  genvar gi;
  generate
    for (gi = 0; gi < NR; gi++) begin : g_rule
      if (gi < NUM_RULES) begin : g_active
        assign rule_hit[gi] = (mask_reg[gi] != 32'd0) &&
                              ((in_instr & mask_reg[gi]) == match_reg[gi]);
      end else begin : g_unused
        assign rule_hit[gi] = 1'b0;
      end
    end
  endgenerate

  assign match = (|(cls & class_en_reg)) | (|rule_hit);

  // Mode selects how the match result turns into a keep decision
  always_comb begin
    mode_keep = 1'b1;
    case (mode_reg)
      MODE_PASS_ALL:   mode_keep = 1'b1;
      MODE_KEEP_MATCH: mode_keep = match;
      MODE_DROP_MATCH: mode_keep = !match;
      MODE_DROP_ALL:   mode_keep = 1'b0;
      default:         mode_keep = 1'b1;
    endcase
  end

`ifdef TRACE_FILTER_PC_RANGE_EN
  logic [PC_WIDTH-1:0] pc_lo_reg;
  logic [PC_WIDTH-1:0] pc_hi_reg;

  // Regs 12/13 belong to the pc window, so a sixth rule cannot be written
  assign rule_addr_ok = (cfg_addr != 4'd12) && (cfg_addr != 4'd13);
  // Inclusive unsigned window; an inverted window rejects every pc
  assign in_range     = (in_pc >= pc_lo_reg) && (in_pc <= pc_hi_reg);

  // pc window registers, reset to the full address space
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_lo_reg <= '0;
      pc_hi_reg <= '1;
    end else if (cfg_wr_en) begin
      if (cfg_addr == 4'd12) pc_lo_reg <= cfg_wdata[PC_WIDTH-1:0];
      if (cfg_addr == 4'd13) pc_hi_reg <= cfg_wdata[PC_WIDTH-1:0];
    end
  end
`else
  assign rule_addr_ok = 1'b1;
  assign in_range     = 1'b1;
`endif

  assign keep = mode_keep & in_range;

  // Configuration register file; a write is seen by entries accepted later
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg     <= MODE_KEEP_MATCH;
      class_en_reg <= 7'h7F;
      for (int k = 0; k < NR; k++) begin
        mask_reg[k]  <= '0;
        match_reg[k] <= '0;
      end
    end else if (cfg_wr_en) begin
      if (cfg_addr == ADDR_MODE)     mode_reg     <= cfg_wdata[1:0];
      if (cfg_addr == ADDR_CLASS_EN) class_en_reg <= cfg_wdata[6:0];
      for (int k = 0; k < NUM_RULES; k++) begin
        if (rule_addr_ok && (cfg_addr == 4'(2 + 2 * k))) mask_reg[k]  <= cfg_wdata;
        if (rule_addr_ok && (cfg_addr == 4'(3 + 2 * k))) match_reg[k] <= cfg_wdata;
      end
    end
  end

  // A dropped entry leaves s1 on its own; a kept one waits for out_ready
  assign retire   = s1_valid_reg && (!s1_keep_reg || out_ready);
  assign in_ready = !s1_valid_reg || !s1_keep_reg || out_ready;
  assign accept   = in_valid && in_ready;

  // Single output stage: load on accept, empty on retire without refill
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_keep_reg  <= 1'b0;
      s1_pc_reg    <= '0;
      s1_instr_reg <= '0;
      s1_class_reg <= '0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_keep_reg  <= keep;
      s1_pc_reg    <= in_pc;
      s1_instr_reg <= in_instr;
      s1_class_reg <= cls;
    end else if (retire) begin
      s1_valid_reg <= 1'b0;
    end
  end

  assign cnt_clear = cfg_wr_en && (cfg_addr == ADDR_CLEAR);

  // Saturating retire counters; a clear beats a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || cnt_clear) begin
      pass_count_reg <= '0;
      drop_count_reg <= '0;
    end else if (retire) begin
      if (s1_keep_reg && (pass_count_reg != '1))
        pass_count_reg <= pass_count_reg + CNT_WIDTH'(1);
      if (!s1_keep_reg && (drop_count_reg != '1))
        drop_count_reg <= drop_count_reg + CNT_WIDTH'(1);
    end
  end

  assign out_valid  = s1_valid_reg && s1_keep_reg;
  assign out_pc     = s1_pc_reg;
  assign out_instr  = s1_instr_reg;
  assign out_class  = s1_class_reg;
  assign pass_count = pass_count_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_trace_filter_stream.sv
// Testbench for trace_filter_stream: directed scenarios plus random traffic,
// scored against a behavioural model through an expected-output queue.
module tb_trace_filter_stream;

  localparam int PC_WIDTH  = 32;
  localparam int NUM_RULES = 4;
  localparam int CNT_WIDTH = 4;
  localparam int RV32      = 1;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [PC_WIDTH-1:0]  in_pc;
  logic [31:0]          in_instr;
  logic                 out_valid;
  logic                 out_ready;
  logic [PC_WIDTH-1:0]  out_pc;
  logic [31:0]          out_instr;
  logic [6:0]           out_class;
  logic                 cfg_wr_en;
  logic [3:0]           cfg_addr;
  logic [31:0]          cfg_wdata;
  logic [CNT_WIDTH-1:0] pass_count;
  logic [CNT_WIDTH-1:0] drop_count;

  trace_filter_stream #(
    .PC_WIDTH (PC_WIDTH),
    .NUM_RULES(NUM_RULES),
    .CNT_WIDTH(CNT_WIDTH),
    .RV32     (RV32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_class (out_class),
    .cfg_wr_en (cfg_wr_en),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .pass_count(pass_count),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  cls;
    int          acc_cyc;
  } exp_t;

  exp_t exp_q[$];

  // Reference configuration
  logic [1:0]  m_mode;
  logic [6:0]  m_class_en;
  logic [31:0] m_mask  [NUM_RULES];
  logic [31:0] m_match [NUM_RULES];
  logic [31:0] m_pc_lo;
  logic [31:0] m_pc_hi;
  int          pass_m;
  int          drop_m;
  bit          drop_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [6:0] ref_class(input logic [31:0] i);
    logic [6:0] c;
    bit comp;
    c    = '0;
    comp = (i[1:0] != 2'b11);
    if (i[6:0] == 7'h63) c[0] = 1'b1;
    if (i[6:0] == 7'h6F) c[1] = 1'b1;
    if (i[6:0] == 7'h67) c[2] = 1'b1;
    if (comp && i[1:0] == 2'b01 && i[15:14] == 2'b11) c[3] = 1'b1;
    if (comp && i[1:0] == 2'b01 && (i[15:13] == 3'd5 || (RV32 == 1 && i[15:13] == 3'd1))) c[4] = 1'b1;
    if (comp && i[1:0] == 2'b10 && i[15:13] == 3'd4 && i[6:2] == 5'd0 && i[11:7] != 5'd0) c[5] = 1'b1;
    if (i == 32'h1050_0073) c[6] = 1'b1;
    return c;
  endfunction

  function automatic bit ref_keep(input logic [31:0] pc, input logic [31:0] instr);
    bit m;
    bit k;
    m = ((ref_class(instr) & m_class_en) != 7'd0);
    for (int r = 0; r < NUM_RULES; r++)
      if (m_mask[r] != 0 && (instr & m_mask[r]) == m_match[r]) m = 1;
    case (m_mode)
      2'd0:    k = 1;
      2'd1:    k = m;
      2'd2:    k = !m;
      default: k = 0;
    endcase
`ifdef TRACE_FILTER_PC_RANGE_EN
    if (pc < m_pc_lo || pc > m_pc_hi) k = 0;
`endif
    return k;
  endfunction

  task automatic model_reset();
    m_mode     = 2'd1;
    m_class_en = 7'h7F;
    for (int r = 0; r < NUM_RULES; r++) begin
      m_mask[r]  = 0;
      m_match[r] = 0;
    end
    m_pc_lo = 0;
    m_pc_hi = 32'hFFFF_FFFF;
  endtask

  // Reference model: predicts kept entries and drop counting per cycle
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_reset();
      drop_m    = 0;
      drop_pend = 0;
    end else begin
      if (cfg_wr_en && cfg_addr == 4'd15) drop_m = 0;
      else if (drop_pend && drop_m < CNT_MAX) drop_m++;
      drop_pend = 0;
      if (in_valid && in_ready) begin
        if (ref_keep(in_pc, in_instr))
          exp_q.push_back('{pc: in_pc, instr: in_instr, cls: ref_class(in_instr), acc_cyc: cyc});
        else
          drop_pend = 1;
      end
      if (cfg_wr_en) begin
        if (cfg_addr == 4'd0) m_mode = cfg_wdata[1:0];
        if (cfg_addr == 4'd1) m_class_en = cfg_wdata[6:0];
        for (int r = 0; r < NUM_RULES; r++) begin
          if (int'(cfg_addr) == 2 + 2 * r) m_mask[r]  = cfg_wdata;
          if (int'(cfg_addr) == 3 + 2 * r) m_match[r] = cfg_wdata;
        end
`ifdef TRACE_FILTER_PC_RANGE_EN
        if (cfg_addr == 4'd12) m_pc_lo = cfg_wdata;
        if (cfg_addr == 4'd13) m_pc_hi = cfg_wdata;
`endif
      end
    end
  end

  // Monitor: pops and compares whenever the DUT presents an entry
  bit held = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pass_m = 0;
      held   = 0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q[0];
          if (!held) check("latency", cyc, e.acc_cyc + 1);
          check("out_pc", out_pc, e.pc);
          check("out_instr", out_instr, e.instr);
          check("out_class", 32'(out_class), 32'(e.cls));
          if (out_ready) begin
            void'(exp_q.pop_front());
            $display("[TB] out pc=%h instr=%h class=%h", e.pc, e.instr, e.cls);
            if (pass_m < CNT_MAX) pass_m++;
          end
        end
      end
      if (cfg_wr_en && cfg_addr == 4'd15) pass_m = 0;
      held = out_valid && !out_ready;
    end
  end

  // Counter check, sampled just after each active edge
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      check("pass_count", 32'(pass_count), pass_m);
      check("drop_count", 32'(drop_count), drop_m);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    cfg_wr_en = 1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_wr_en = 0;
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] instr);
    bit acc;
    int n;
    in_valid = 1;
    in_pc    = pc;
    in_instr = instr;
    acc      = 0;
    n        = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      n++;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no accept, required accept of instr %h", instr);
    end
    in_valid = 0;
  endtask

  task automatic drain(input int n);
    in_valid  = 0;
    out_ready = 1;
    repeat (n) tick();
  endtask

  logic [31:0] pool [12];

  initial begin
    pool[0]  = 32'h0000_0063;
    pool[1]  = 32'h0000_006F;
    pool[2]  = 32'h0000_0067;
    pool[3]  = 32'h0000_0013;
    pool[4]  = 32'h1050_0073;
    pool[5]  = 32'h0000_C001;
    pool[6]  = 32'h0000_A001;
    pool[7]  = 32'h0000_2001;
    pool[8]  = 32'h0000_8082;
    pool[9]  = 32'h0000_8002;
    pool[10] = 32'h0000_9082;
    pool[11] = 32'h00B5_0533;

    rst = 1; in_valid = 0; in_pc = 0; in_instr = 0; out_ready = 1;
    cfg_wr_en = 0; cfg_addr = 0; cfg_wdata = 0;
    tick();
    chk_en = 1;
    tick();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_class", 32'(out_class), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 0;
    tick();

    // Default mode keeps control flow only
    send(32'h0, 32'h0000_0063);
    send(32'h4, 32'h0000_0013);
    send(32'h8, 32'h1050_0073);
    drain(3);
    check("basic_pass_count", 32'(pass_count), 32'd2);
    check("basic_drop_count", 32'(drop_count), 32'd1);

    // Back-pressure: first entry held, input stalled
    cfg_write(4'd0, 32'd0);
    out_ready = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(32'h100 + 32'(4 * i), 32'h0000_0013 + 32'(i << 7));
      end
      begin
        repeat (6) tick();
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1;
      end
    join
    drain(3);
    check("stall_queue_empty", exp_q.size(), 0);

    // Programmable rule only
    cfg_write(4'd2, 32'h7F);
    cfg_write(4'd3, 32'h33);
    cfg_write(4'd1, 32'h0);
    cfg_write(4'd0, 32'h1);
    send(32'h200, 32'h00B5_0533);
    send(32'h204, 32'h0000_006F);
    drain(3);

    // Drop-match with compressed jumps
    cfg_write(4'd1, 32'h7F);
    cfg_write(4'd0, 32'h2);
    send(32'h300, 32'h0000_8082);
    send(32'h302, 32'h0000_8002);
    drain(3);
    cfg_write(4'd2, 32'h0);

    // Saturation of drop_count and clear winning over a drop
    cfg_write(4'd0, 32'h3);
    cfg_write(4'd15, 32'h0);
    in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      in_pc    = 32'h400 + 32'(i);
      in_instr = $urandom;
      tick();
    end
    in_valid  = 0;
    cfg_wr_en = 1;
    cfg_addr  = 4'd15;
    @(negedge clk);
    check("drop_saturated", 32'(drop_count), 32'hF);
    @(posedge clk);
    #1;
    cfg_wr_en = 0;
    @(negedge clk);
    check("clear_wins", 32'(drop_count), 32'd0);
    @(posedge clk);
    #1;

`ifdef TRACE_FILTER_PC_RANGE_EN
    cfg_write(4'd12, 32'h100);
    cfg_write(4'd13, 32'h1FF);
    cfg_write(4'd0, 32'h0);
    cfg_write(4'd15, 32'h0);
    send(32'hFF, 32'h13);
    send(32'h100, 32'h13);
    send(32'h1FF, 32'h13);
    send(32'h200, 32'h13);
    drain(3);
    check("range_pass_count", 32'(pass_count), 32'd2);
    check("range_drop_count", 32'(drop_count), 32'd2);
    cfg_write(4'd12, 32'h0);
    cfg_write(4'd13, 32'hFFFF_FFFF);
`endif

    // Random traffic with occasional configuration writes
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pc     = $urandom_range(0, 1023);
      in_instr  = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 11)];
      out_ready = ($urandom_range(0, 2) != 0);
      cfg_wr_en = ($urandom_range(0, 19) == 0);
      cfg_addr  = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0:       cfg_wdata = $urandom;
        1:       cfg_wdata = 32'h7F;
        default: cfg_wdata = {22'd0, 10'($urandom_range(0, 1023))} & 32'h3FF;
      endcase
      if (cfg_addr == 4'd3 || cfg_addr == 4'd5) cfg_wdata = pool[$urandom_range(0, 11)] & 32'h7F;
      tick();
    end
    cfg_wr_en = 0;
    drain(5);
    check("random_queue_empty", exp_q.size(), 0);

    // Reset with a held entry discards it without counting
    cfg_write(4'd0, 32'h0);
    out_ready = 0;
    send(32'h500, 32'h13);
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_pass_count", 32'(pass_count), 32'd0);
    @(posedge clk);
    #1;
    drain(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
